// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Initiator-side controller for the 64-bit uPOWER ALU. Accepts one operation at a
// time over a valid/ready handshake, drives registered operands and the 4-bit ALU
// control {Ainvert,Binvert,Operation[1:0]}, and holds the captured result in a
// response buffer until the consumer takes it. CMP runs as a SUB pass followed by
// an SLT pass and returns a CR-style {LT,GT,EQ} field.
// Optional feature macro: SO_STICKY_EN (sticky summary-overflow bit with so_clear).

module alu_op_sequencer #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_func,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_ovf,
   output logic [2:0]       rsp_cr,
   output logic             rsp_illegal,
   input  logic             so_clear,
   output logic             sticky_so
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [2:0] FUNC_CMP     = 3'd6;
   localparam logic [2:0] FUNC_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CMP2 = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aluA_q, aluA_d;
   logic [WIDTH-1:0] aluB_q, aluB_d;
   logic [3:0]       aluOp_q, aluOp_d;
   logic             isCmp_q, isCmp_d;
   logic [WIDTH-1:0] rspResult_q, rspResult_d;
   logic             rspZero_q, rspZero_d;
   logic             rspOvf_q, rspOvf_d;
   logic [2:0]       rspCr_q, rspCr_d;
   logic             rspIllegal_q, rspIllegal_d;

   logic             accept;
   logic             ovfMasked;
   logic             sltBit;

   // Function code to ALU control; CMP starts with the SUB pass, illegal leaves the ALU idle
   function automatic logic [3:0] decodeOp(input logic [2:0] func);
      logic [3:0] op;
      case (func)
         3'd0:    op = OP_AND;
         3'd1:    op = OP_OR;
         3'd2:    op = OP_ADD;
         3'd3:    op = OP_SUB;
         3'd4:    op = OP_SLT;
         3'd5:    op = OP_NOR;
         3'd6:    op = OP_SUB;
         default: op = OP_AND;
      endcase
      return op;
   endfunction

   assign accept    = req_valid && (state_q == IDLE);
   assign ovfMasked = alu_overflow && ((aluOp_q == OP_ADD) || (aluOp_q == OP_SUB));
   assign sltBit    = alu_result[0];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: IDLE -> EXEC -> [CMP2] -> RESP -> IDLE, illegal skips straight to RESP
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (req_func == FUNC_ILLEGAL) ? RESP : EXEC;
            end
         end
         EXEC: state_d = isCmp_q ? CMP2 : RESP;
         CMP2: state_d = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs follow the state directly so they drop the cycle after a transfer
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
   end

   // Datapath next values: latch operands on accept, capture ALU outputs in EXEC/CMP2
   always_comb begin
      aluA_d       = aluA_q;
      aluB_d       = aluB_q;
      aluOp_d      = aluOp_q;
      isCmp_d      = isCmp_q;
      rspResult_d  = rspResult_q;
      rspZero_d    = rspZero_q;
      rspOvf_d     = rspOvf_q;
      rspCr_d      = rspCr_q;
      rspIllegal_d = rspIllegal_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               aluA_d       = req_a;
               aluB_d       = req_b;
               aluOp_d      = decodeOp(req_func);
               isCmp_d      = (req_func == FUNC_CMP);
               rspResult_d  = '0;
               rspZero_d    = 1'b0;
               rspOvf_d     = 1'b0;
               rspCr_d      = 3'b000;
               rspIllegal_d = (req_func == FUNC_ILLEGAL);
            end
         end
         EXEC: begin
            rspResult_d = alu_result;
            rspZero_d   = alu_zero;
            rspOvf_d    = ovfMasked;
            if (isCmp_q) begin
               rspCr_d[0] = alu_zero;
               aluOp_d    = OP_SLT;
            end else begin
               aluOp_d    = OP_AND;
            end
         end
         CMP2: begin
            rspCr_d = {sltBit, ~sltBit & ~rspCr_q[0], rspCr_q[0]};
            aluOp_d = OP_AND;
         end
         default: begin
         end
      endcase
   end

   // Datapath and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         aluA_q       <= '0;
         aluB_q       <= '0;
         aluOp_q      <= OP_AND;
         isCmp_q      <= 1'b0;
         rspResult_q  <= '0;
         rspZero_q    <= 1'b0;
         rspOvf_q     <= 1'b0;
         rspCr_q      <= 3'b000;
         rspIllegal_q <= 1'b0;
      end else begin
         aluA_q       <= aluA_d;
         aluB_q       <= aluB_d;
         aluOp_q      <= aluOp_d;
         isCmp_q      <= isCmp_d;
         rspResult_q  <= rspResult_d;
         rspZero_q    <= rspZero_d;
         rspOvf_q     <= rspOvf_d;
         rspCr_q      <= rspCr_d;
         rspIllegal_q <= rspIllegal_d;
      end
   end

   assign alu_a       = aluA_q;
   assign alu_b       = aluB_q;
   assign alu_op      = aluOp_q;
   assign rsp_result  = rspResult_q;
   assign rsp_zero    = rspZero_q;
   assign rsp_ovf     = rspOvf_q;
   assign rsp_cr      = rspCr_q;
   assign rsp_illegal = rspIllegal_q;

`ifdef SO_STICKY_EN
   logic stickySo_q, stickySo_d;
   logic captureOvf;

   assign captureOvf = (state_q == EXEC) && ovfMasked;

   // Sticky overflow: a new overflow capture wins over a simultaneous clear
   always_comb begin
      stickySo_d = stickySo_q;
      if (captureOvf) begin
         stickySo_d = 1'b1;
      end else if (so_clear) begin
         stickySo_d = 1'b0;
      end
   end

   // Sticky overflow register
   always_ff @(posedge clk) begin
      if (reset) begin
         stickySo_q <= 1'b0;
      end else begin
         stickySo_q <= stickySo_d;
      end
   end

   assign sticky_so = stickySo_q;
`else
   logic unusedSoClear;

   assign unusedSoClear = so_clear;
   assign sticky_so     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Drives alu_op_sequencer against a behavioural 64-bit ALU and checks every cycle
// against a transaction-level reference model. Honours SO_STICKY_EN the same way
// the design does.

module tb_alu_op_sequencer;

   localparam int WIDTH = 64;

   logic             clk;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_func;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             alu_overflow;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_ovf;
   logic [2:0]       rsp_cr;
   logic             rsp_illegal;
   logic             so_clear;
   logic             sticky_so;

   int checkCount = 0;
   int failCount  = 0;

   alu_op_sequencer #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_func     (req_func),
      .req_a        (req_a),
      .req_b        (req_b),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_ovf      (rsp_ovf),
      .rsp_cr       (rsp_cr),
      .rsp_illegal  (rsp_illegal),
      .so_clear     (so_clear),
      .sticky_so    (sticky_so)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: invert, add with carry-in, then pick the operation
   logic [63:0] aluAIn, aluBIn, aluSum;
   logic        aluOvfW;
   always_comb begin
      aluAIn  = alu_op[3] ? ~alu_a : alu_a;
      aluBIn  = alu_op[2] ? ~alu_b : alu_b;
      aluSum  = aluAIn + aluBIn + {63'd0, alu_op[2]};
      aluOvfW = (aluAIn[63] == aluBIn[63]) && (aluSum[63] != aluAIn[63]);
      case (alu_op[1:0])
         2'b00:   alu_result = aluAIn & aluBIn;
         2'b01:   alu_result = aluAIn | aluBIn;
         2'b10:   alu_result = aluSum;
         default: alu_result = {63'd0, aluSum[63] ^ aluOvfW};
      endcase
      alu_zero     = (alu_result == 64'd0);
      alu_overflow = aluOvfW;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model functions, straight from the operation definitions
   function automatic logic [63:0] refResult(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      case (f)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         3'd5:    return ~(a | b);
         3'd6:    return a - b;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic refOvf(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      logic signed [64:0] wide;
      if (f == 3'd2) wide = $signed({a[63], a}) + $signed({b[63], b});
      else if (f == 3'd3 || f == 3'd6) wide = $signed({a[63], a}) - $signed({b[63], b});
      else return 1'b0;
      return wide[64] != wide[63];
   endfunction

   function automatic logic [2:0] refCr(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      if (f != 3'd6) return 3'b000;
      return {$signed(a) < $signed(b), $signed(a) > $signed(b), a == b};
   endfunction

   function automatic logic [3:0] refOp(input logic [2:0] f);
      case (f)
         3'd0:    return 4'b0000;
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0010;
         3'd3:    return 4'b0110;
         3'd4:    return 4'b0111;
         3'd5:    return 4'b1100;
         3'd6:    return 4'b0110;
         default: return 4'b0000;
      endcase
   endfunction

   // Model state: one transaction in flight, with cycles left until its response shows
   bit          mKnown = 0;
   bit          mBusy, mFresh, mCmp, mIllegal, mSticky;
   int          mLeft;
   logic [3:0]  mOp;
   logic [63:0] mA, mB, mRes;
   logic        mZero, mOvf;
   logic [2:0]  mCr;

   // Compare process: check outputs mid-cycle, then advance the model by the coming edge
   always @(negedge clk) begin
      logic [3:0] expOp;
      if (mKnown) begin
         expOp = 4'b0000;
         if (mBusy && !mIllegal) begin
            if (mCmp) expOp = (mLeft == 2) ? 4'b0110 : ((mLeft == 1) ? 4'b0111 : 4'b0000);
            else      expOp = (mLeft == 1) ? mOp : 4'b0000;
         end
         checkOutput("req_ready", req_ready, !mBusy);
         checkOutput("rsp_valid", rsp_valid, mBusy && mLeft == 0);
         checkOutput("alu_op", alu_op, expOp);
         checkOutput("sticky_so", sticky_so, mSticky);
         if (mBusy && !mIllegal && mLeft > 0) begin
            checkOutput("alu_a", alu_a, mA);
            checkOutput("alu_b", alu_b, mB);
         end
         if (mBusy && mLeft == 0) begin
            checkOutput("rsp_result", rsp_result, mRes);
            checkOutput("rsp_zero", rsp_zero, mZero);
            checkOutput("rsp_ovf", rsp_ovf, mOvf);
            checkOutput("rsp_cr", rsp_cr, mCr);
            checkOutput("rsp_illegal", rsp_illegal, mIllegal);
         end
         if (mFresh) begin
            checkOutput("reset alu_a", alu_a, 64'd0);
            checkOutput("reset alu_b", alu_b, 64'd0);
            checkOutput("reset rsp_result", rsp_result, 64'd0);
            checkOutput("reset rsp_flags", {rsp_zero, rsp_ovf, rsp_cr, rsp_illegal}, 64'd0);
         end
      end
      if (reset) begin
         mKnown = 1; mBusy = 0; mLeft = 0; mFresh = 1; mSticky = 0;
         mCmp = 0; mIllegal = 0;
      end else if (mKnown) begin
`ifdef SO_STICKY_EN
         if (mBusy && !mIllegal && mLeft == (mCmp ? 2 : 1) && mOvf) mSticky = 1;
         else if (so_clear) mSticky = 0;
`endif
         if (!mBusy) begin
            if (req_valid) begin
               mBusy    = 1;
               mFresh   = 0;
               mA       = req_a;
               mB       = req_b;
               mOp      = refOp(req_func);
               mCmp     = (req_func == 3'd6);
               mIllegal = (req_func == 3'd7);
               mRes     = refResult(req_func, req_a, req_b);
               mZero    = !mIllegal && (mRes == 64'd0);
               mOvf     = refOvf(req_func, req_a, req_b);
               mCr      = refCr(req_func, req_a, req_b);
               mLeft    = mIllegal ? 0 : (mCmp ? 2 : 1);
            end
         end else if (mLeft > 0) begin
            mLeft--;
         end else if (rsp_ready) begin
            mBusy = 0;
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                input logic rr, input logic sc, input logic rst);
      req_valid = v; req_func = f; req_a = a; req_b = b;
      rsp_ready = rr; so_clear = sc; reset = rst;
   endtask

   task automatic waitReady();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("ready timeout", req_ready, 1'b1);
   endtask

   // One full transaction with rsp_ready high; latency counted in edges from the accept edge
   task automatic doOp(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, output int lat,
                       output logic [63:0] res, output logic z, output logic o, output logic il, output logic [2:0] cr);
      waitReady();
      applyStimulus(1'b1, f, a, b, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      res = rsp_result; z = rsp_zero; o = rsp_ovf; il = rsp_illegal; cr = rsp_cr;
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return {$urandom, $urandom};
         1:       return 64'($urandom_range(0, 15));
         2:       return 64'h7FFF_FFFF_FFFF_FFFF;
         3:       return 64'h8000_0000_0000_0000;
         4:       return '1;
         default: return 64'd0 - 64'($urandom_range(1, 9));
      endcase
   endfunction

   initial begin
      int          lat;
      logic [63:0] res, a, b;
      logic        z, o, il;
      logic [2:0]  cr;

      applyStimulus(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("reset req_ready", req_ready, 1'b1);
      checkOutput("reset rsp_valid", rsp_valid, 1'b0);

      doOp(3'd2, 64'd5, 64'd7, lat, res, z, o, il, cr);
      checkOutput("add latency", 64'(lat), 64'd2);
      checkOutput("add result", res, 64'd12);
      checkOutput("add flags", {z, o}, 64'd0);

      doOp(3'd3, 64'h1234, 64'h1234, lat, res, z, o, il, cr);
      checkOutput("sub result", res, 64'd0);
      checkOutput("sub zero", z, 1'b1);
      doOp(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat, res, z, o, il, cr);
      checkOutput("add ovf result", res, 64'h8000_0000_0000_0000);
      checkOutput("add ovf", o, 1'b1);

      doOp(3'd6, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, lat, res, z, o, il, cr);
      checkOutput("cmp lt cr", cr, 3'b100);
      checkOutput("cmp lt result", res, 64'hFFFF_FFFF_FFFF_FFFB);
      checkOutput("cmp latency", 64'(lat), 64'd3);
      doOp(3'd6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, lat, res, z, o, il, cr);
      checkOutput("cmp gt cr", cr, 3'b010);
      doOp(3'd6, 64'd9, 64'd9, lat, res, z, o, il, cr);
      checkOutput("cmp eq cr", cr, 3'b001);
      checkOutput("cmp eq zero", z, 1'b1);

      doOp(3'd0, 64'hF0F0, 64'hFF00, lat, res, z, o, il, cr);
      checkOutput("and result", res, 64'hF000);
      checkOutput("and ovf", o, 1'b0);
      doOp(3'd1, 64'hF0F0, 64'hFF00, lat, res, z, o, il, cr);
      checkOutput("or result", res, 64'hFFF0);
      doOp(3'd5, 64'hF0F0, 64'hFF00, lat, res, z, o, il, cr);
      checkOutput("nor result", res, 64'hFFFF_FFFF_FFFF_000F);
      checkOutput("nor ovf", o, 1'b0);
      doOp(3'd7, 64'd3, 64'd4, lat, res, z, o, il, cr);
      checkOutput("illegal flag", il, 1'b1);
      checkOutput("illegal latency", 64'(lat), 64'd1);
      checkOutput("illegal result", res, 64'd0);

      // Response held under back-pressure while a second request waits
      waitReady();
      applyStimulus(1'b1, 3'd2, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      req_func = 3'd0; req_a = 64'd1; req_b = 64'd1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("hold result", rsp_result, 64'd7);
         checkOutput("hold valid", rsp_valid, 1'b1);
         checkOutput("hold ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      checkOutput("queued and result", rsp_result, 64'd1);
      @(posedge clk); #1;

      // Reset during the EXEC cycle of a CMP
      waitReady();
      applyStimulus(1'b1, 3'd6, 64'd5, 64'd3, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("midreset rsp_valid", rsp_valid, 1'b0);
      checkOutput("midreset alu_op", alu_op, 4'b0000);
      checkOutput("midreset rsp_cr", rsp_cr, 3'b000);
      checkOutput("midreset req_ready", req_ready, 1'b1);
      doOp(3'd2, 64'd1, 64'd2, lat, res, z, o, il, cr);
      checkOutput("post reset add", res, 64'd3);

`ifdef SO_STICKY_EN
      doOp(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat, res, z, o, il, cr);
      checkOutput("sticky set", sticky_so, 1'b1);
      doOp(3'd2, 64'd1, 64'd1, lat, res, z, o, il, cr);
      checkOutput("sticky hold", sticky_so, 1'b1);
      so_clear = 1'b1;
      @(posedge clk); #1;
      so_clear = 1'b0;
      checkOutput("sticky clear", sticky_so, 1'b0);
`endif

      for (int i = 0; i < 600; i++) begin
         a = pickOperand();
         b = ($urandom_range(0, 3) == 0) ? a : pickOperand();
         applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), a, b,
                       $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
         @(posedge clk); #1;
      end
      applyStimulus(1'b0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
